// File: rtl/xadc_wave_gen.sv
// xadc_wave_gen: double-buffered XADC capture drawn as a trace over the VGA active area.
// Define XADC_WAVE_GRID_EN to overlay an 80x60-pixel graticule.
module xadc_wave_gen #(
   parameter logic [11:0] TRACE_COLOR = 12'h0F0,
   parameter logic [11:0] BG_COLOR    = 12'h000,
   parameter logic [11:0] GRID_COLOR  = 12'h444
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        cnt3,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        sample_valid,
   input  logic [11:0] sample_data,
   output logic        sample_ready,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);
   logic [8:0] bank0 [0:639];
   logic [8:0] bank1 [0:639];
   logic [9:0] wr_ptr;
   logic       full, disp_valid, sel;
   logic       accept, wr_en, swap, grid_hit;
   logic [8:0] row_in, rd_row, d_row;
   logic [9:0] p_y;
   logic       p_v, p_hs, p_vs;
   logic       unused_lsbs;

   assign unused_lsbs  = ^sample_data[2:0];
   assign sample_ready = !full;
   assign accept       = sample_valid && sample_ready;
   assign wr_en        = accept && !reset;
   assign swap         = cnt3 && pixel_x == 10'd0 && pixel_y == 10'd480;
   assign row_in       = 9'd479 - ((sample_data[11:3] > 9'd479) ? 9'd479 : sample_data[11:3]);

   // sel=0: bank0 captures while bank1 is displayed
   always_comb begin
      rd_row = 9'd0;
      if (pixel_x < 10'd640) rd_row = sel ? bank0[pixel_x] : bank1[pixel_x];
   end

   always_ff @(posedge clk)
      if (wr_en) begin
         if (sel) bank1[wr_ptr] <= row_in;
         else     bank0[wr_ptr] <= row_in;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr     <= 10'd0;
         full       <= 1'b0;
         disp_valid <= 1'b0;
         sel        <= 1'b0;
      end else if (swap && full) begin
         sel        <= !sel;
         wr_ptr     <= 10'd0;
         full       <= 1'b0;
         disp_valid <= 1'b1;
      end else if (accept) begin
         wr_ptr <= wr_ptr + 10'd1;
         full   <= wr_ptr == 10'd639;
      end

`ifdef XADC_WAVE_GRID_EN
   logic [9:0] p_x;
   always_ff @(posedge clk or posedge reset)
      if (reset)     p_x <= 10'd0;
      else if (cnt3) p_x <= pixel_x;
   assign grid_hit = (p_x % 10'd80 == 10'd0) || (p_y % 10'd60 == 10'd0);
`else
   assign grid_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         d_row <= 9'd0;
         p_y   <= 10'd0;
         p_v   <= 1'b0;
         p_hs  <= 1'b0;
         p_vs  <= 1'b0;
         rgb   <= 12'h000;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else if (cnt3) begin
         d_row <= rd_row;
         p_y   <= pixel_y;
         p_v   <= video_on;
         p_hs  <= hsync_in;
         p_vs  <= vsync_in;
         rgb   <= !p_v ? 12'h000 :
                  (disp_valid && p_y == {1'b0, d_row}) ? TRACE_COLOR :
                  grid_hit ? GRID_COLOR : BG_COLOR;
         hsync <= p_hs;
         vsync <= p_vs;
      end
endmodule
